// File: rtl/simplez_loader_if.sv
// Byte-receive and program-memory write bus of the Simplez serial loader.
// The loader takes the master view: it consumes received bytes and drives
// the memory write port. The slave view belongs to the UART/memory side.
interface simplez_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [8:0]  mem_addr;
  logic [11:0] mem_data;
  logic        mem_wr;

  modport master (
    input  rx_data,
    input  rx_valid,
    output mem_addr,
    output mem_data,
    output mem_wr
  );

  modport slave (
    output rx_data,
    output rx_valid,
    input  mem_addr,
    input  mem_data,
    input  mem_wr
  );
endinterface

// File: rtl/simplez_loader.sv
// Simplez serial program loader.
// Parses frames  A5 | CNT_H | CNT_L | {HI LO} x count | CHK  from the UART,
// writes each 12-bit word into program memory and releases the CPU reset only
// after a frame whose checksum matches. Everything runs on the falling clock
// edge so the memory and CPU see stable write data on their own edges.
module simplez_loader #(
  parameter int MAXW = 512
) (
  input  logic              clk,
  input  logic              rstn,
  simplez_loader_if.master  bus,
  output logic              cpu_rstn,
  output logic              busy,
  output logic              err
);

  typedef enum logic [2:0] {
    SYNC  = 3'd0,
    CNT_H = 3'd1,
    CNT_L = 3'd2,
    DAT_H = 3'd3,
    DAT_L = 3'd4,
    CHK   = 3'd5,
    RUN   = 3'd6,
    ERR   = 3'd7
  } state_t;

  localparam logic [7:0]  SYNC_BYTE = 8'hA5;
  localparam logic [10:0] MAXW_C    = 11'(MAXW);

  // Modulo-256 running sum of payload bytes.
  function automatic logic [7:0] chk_add(input logic [7:0] acc, input logic [7:0] b);
    chk_add = acc + b;
  endfunction

  // States in which a frame is being received.
  function automatic logic state_is_busy(input state_t s);
    case (s)
      CNT_H, CNT_L, DAT_H, DAT_L, CHK: state_is_busy = 1'b1;
      default:                         state_is_busy = 1'b0;
    endcase
  endfunction

  state_t      state_r,    state_nxt_s;
  logic [1:0]  cnt_hi_r,   cnt_hi_nxt_s;
  logic [9:0]  remain_r,   remain_nxt_s;
  logic [8:0]  addr_r,     addr_nxt_s;
  logic [3:0]  hi_r,       hi_nxt_s;
  logic [7:0]  chk_r,      chk_nxt_s;
  logic [8:0]  mem_addr_r, mem_addr_nxt_s;
  logic [11:0] mem_data_r, mem_data_nxt_s;
  logic        mem_wr_r,   mem_wr_nxt_s;
  logic        cpu_rstn_r, cpu_rstn_nxt_s;
  logic        busy_r,     busy_nxt_s;
  logic        err_r,      err_nxt_s;
  logic [9:0]  count_s;

  // Frame parser: next state, datapath updates and next registered outputs.
  always_comb begin
    state_nxt_s    = state_r;
    cnt_hi_nxt_s   = cnt_hi_r;
    remain_nxt_s   = remain_r;
    addr_nxt_s     = addr_r;
    hi_nxt_s       = hi_r;
    chk_nxt_s      = chk_r;
    mem_addr_nxt_s = mem_addr_r;
    mem_data_nxt_s = mem_data_r;
    mem_wr_nxt_s   = 1'b0;
    count_s        = {cnt_hi_r, bus.rx_data};

    if (bus.rx_valid) begin
      case (state_r)
        SYNC, RUN, ERR: begin
          // Outside a frame only the sync byte matters; program I/O is ignored.
          if (bus.rx_data == SYNC_BYTE) begin
            state_nxt_s = CNT_H;
          end else begin
            state_nxt_s = state_r;
          end
        end
        CNT_H: begin
          cnt_hi_nxt_s = bus.rx_data[1:0];
          state_nxt_s  = CNT_L;
        end
        CNT_L: begin
          remain_nxt_s = count_s;
          addr_nxt_s   = 9'd0;
          chk_nxt_s    = 8'h00;
          if ({1'b0, count_s} > MAXW_C) begin
            state_nxt_s = ERR;
          end else if (count_s == 10'd0) begin
            state_nxt_s = CHK;
          end else begin
            state_nxt_s = DAT_H;
          end
        end
        DAT_H: begin
          hi_nxt_s    = bus.rx_data[3:0];
          chk_nxt_s   = chk_add(chk_r, bus.rx_data);
          state_nxt_s = DAT_L;
        end
        DAT_L: begin
          mem_wr_nxt_s   = 1'b1;
          mem_addr_nxt_s = addr_r;
          mem_data_nxt_s = {hi_r, bus.rx_data};
          chk_nxt_s      = chk_add(chk_r, bus.rx_data);
          addr_nxt_s     = addr_r + 9'd1;
          remain_nxt_s   = remain_r - 10'd1;
          if (remain_r == 10'd1) begin
            state_nxt_s = CHK;
          end else begin
            state_nxt_s = DAT_H;
          end
        end
        CHK: begin
          if (bus.rx_data == chk_r) begin
            state_nxt_s = RUN;
          end else begin
            state_nxt_s = ERR;
          end
        end
        default: state_nxt_s = SYNC;
      endcase
    end else begin
      state_nxt_s = state_r;
    end

    // Status outputs are registered from the state being entered, so they
    // change on the same edge as the state itself.
    busy_nxt_s     = state_is_busy(state_nxt_s);
    cpu_rstn_nxt_s = (state_nxt_s == RUN);
    err_nxt_s      = (state_nxt_s == ERR);
  end

  // State and datapath registers, synchronous active-low reset, falling edge.
  always_ff @(negedge clk) begin
    if (!rstn) begin
      state_r    <= SYNC;
      cnt_hi_r   <= 2'd0;
      remain_r   <= 10'd0;
      addr_r     <= 9'd0;
      hi_r       <= 4'd0;
      chk_r      <= 8'h00;
      mem_addr_r <= 9'd0;
      mem_data_r <= 12'd0;
      mem_wr_r   <= 1'b0;
      cpu_rstn_r <= 1'b0;
      busy_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cnt_hi_r   <= cnt_hi_nxt_s;
      remain_r   <= remain_nxt_s;
      addr_r     <= addr_nxt_s;
      hi_r       <= hi_nxt_s;
      chk_r      <= chk_nxt_s;
      mem_addr_r <= mem_addr_nxt_s;
      mem_data_r <= mem_data_nxt_s;
      mem_wr_r   <= mem_wr_nxt_s;
      cpu_rstn_r <= cpu_rstn_nxt_s;
      busy_r     <= busy_nxt_s;
      err_r      <= err_nxt_s;
    end
  end

  assign bus.mem_addr = mem_addr_r;
  assign bus.mem_data = mem_data_r;
  assign bus.mem_wr   = mem_wr_r;
  assign cpu_rstn     = cpu_rstn_r;
  assign busy         = busy_r;
  assign err          = err_r;

endmodule

// File: tb/tb_simplez_loader.sv
// Directed plus randomized bench for simplez_loader. Expected memory writes
// and frame outcomes are derived from the frame contents the bench builds.
module tb_simplez_loader;

  logic clk = 1'b0;
  logic rstn;
  logic cpu_rstn;
  logic busy;
  logic err;

  simplez_loader_if mif();

  simplez_loader #(.MAXW(512)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .bus      (mif),
    .cpu_rstn (cpu_rstn),
    .busy     (busy),
    .err      (err)
  );

  // DUT acts on falling edges; the bench drives and samples on rising edges.
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [20:0] wr_q[$];   // observed writes {addr, data}
  logic [20:0] exp_q[$];  // expected writes {addr, data}

  // Record every cycle in which the write strobe is high.
  always @(posedge clk) begin
    if (mif.mem_wr === 1'b1) wr_q.push_back({mif.mem_addr, mif.mem_data});
  end

  // Safety net so the run always ends.
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    @(posedge clk);
    mif.rx_data  = b;
    mif.rx_valid = 1'b1;
    @(posedge clk);
    mif.rx_valid = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Compare recorded writes against the expected list.
  task automatic check_writes(input string tag);
    int mism;
    mism = 0;
    check({tag, "_nwr"}, 32'(wr_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++) begin
      if (wr_q[i] !== exp_q[i]) mism++;
    end
    check({tag, "_wrdata"}, 32'(mism), 32'd0);
  endtask

  task automatic send_list(input logic [7:0] q[$]);
    foreach (q[i]) send(q[i], 0);
  endtask

  // Build, send and check one frame with `cnt` words.
  task automatic run_frame(input int cnt, input bit bad_chk, input bit zero_data);
    logic [7:0] sum, hi, lo, cb;
    logic [9:0] c10;
    bit ok;
    wr_q.delete();
    exp_q.delete();
    sum = 8'h00;
    c10 = 10'(cnt);
    send(8'hA5, int'($urandom_range(0, 1)));
    cb = 8'($urandom);
    cb[1:0] = c10[9:8];
    send(cb, int'($urandom_range(0, 1)));
    send(c10[7:0], int'($urandom_range(0, 1)));
    if (cnt > 512) begin
      ok = 1'b0;
    end else begin
      for (int i = 0; i < cnt; i++) begin
        hi = zero_data ? 8'h00 : 8'($urandom);
        lo = zero_data ? 8'h00 : 8'($urandom);
        exp_q.push_back({9'(i), hi[3:0], lo});
        sum = sum + hi + lo;
        send(hi, zero_data ? 0 : int'($urandom_range(0, 1)));
        send(lo, zero_data ? 0 : int'($urandom_range(0, 1)));
      end
      cb = bad_chk ? sum + 8'(1 + $urandom_range(0, 254)) : sum;
      send(cb, 0);
      ok = !bad_chk;
    end
    settle();
    check_writes("frame");
    check("frame_cpu_rstn", {31'd0, cpu_rstn}, {31'd0, ok});
    check("frame_err", {31'd0, err}, {31'd0, !ok});
    check("frame_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] nb;
    mif.rx_data  = 8'h00;
    mif.rx_valid = 1'b0;

    // Reset state.
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cpu_rstn", {31'd0, cpu_rstn}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_mem_wr", {31'd0, mif.mem_wr}, 32'd0);
    check("rst_mem_addr", 32'(mif.mem_addr), 32'd0);
    check("rst_mem_data", 32'(mif.mem_data), 32'd0);
    rstn = 1'b1;

    // Two-word frame with correct checksum.
    wr_q.delete(); exp_q.delete();
    exp_q.push_back({9'd0, 12'h205});
    exp_q.push_back({9'd1, 12'hE00});
    q = '{8'hA5, 8'h00, 8'h02, 8'h02, 8'h05, 8'h0E, 8'h00, 8'h15};
    send_list(q);
    settle();
    check_writes("good2");
    check("good2_cpu_rstn", {31'd0, cpu_rstn}, 32'd1);
    check("good2_err", {31'd0, err}, 32'd0);
    check("good2_busy", {31'd0, busy}, 32'd0);

    // Same frame, wrong checksum: writes happen, frame rejected.
    wr_q.delete();
    q = '{8'hA5, 8'h00, 8'h02, 8'h02, 8'h05, 8'h0E, 8'h00, 8'h16};
    send_list(q);
    settle();
    check_writes("badchk");
    check("badchk_err", {31'd0, err}, 32'd1);
    check("badchk_cpu_rstn", {31'd0, cpu_rstn}, 32'd0);
    check("badchk_hold_addr", 32'(mif.mem_addr), 32'd1);
    check("badchk_hold_data", 32'(mif.mem_data), 32'hE00);

    // Empty frame recovers from error.
    wr_q.delete(); exp_q.delete();
    q = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_list(q);
    settle();
    check("empty_cpu_rstn", {31'd0, cpu_rstn}, 32'd1);
    check("empty_err", {31'd0, err}, 32'd0);
    check("empty_nwr", 32'(wr_q.size()), 32'd0);

    // Program traffic in RUN is ignored; sync byte starts a reload.
    send(8'h12, 0);
    send(8'h34, 0);
    settle();
    check("run_io_cpu_rstn", {31'd0, cpu_rstn}, 32'd1);
    check("run_io_busy", {31'd0, busy}, 32'd0);
    send(8'hA5, 0);
    #1;
    check("reload_cpu_rstn", {31'd0, cpu_rstn}, 32'd0);
    check("reload_busy", {31'd0, busy}, 32'd1);
    q = '{8'h00, 8'h00, 8'h00};
    send_list(q);
    settle();
    check("reload_done_cpu_rstn", {31'd0, cpu_rstn}, 32'd1);

    // Oversized count is rejected before any write; leading noise ignored.
    wr_q.delete();
    q = '{8'h37, 8'hA5, 8'h02, 8'h01};
    send_list(q);
    settle();
    check("over_err", {31'd0, err}, 32'd1);
    check("over_cpu_rstn", {31'd0, cpu_rstn}, 32'd0);
    check("over_nwr", 32'(wr_q.size()), 32'd0);

    // Reset in the middle of a frame, with a byte coincident with reset.
    q = '{8'hA5, 8'h00, 8'h03, 8'h01};
    send_list(q);
    #1;
    check("midframe_busy", {31'd0, busy}, 32'd1);
    @(posedge clk);
    rstn = 1'b0;
    mif.rx_data  = 8'h01;
    mif.rx_valid = 1'b1;
    @(posedge clk);
    mif.rx_valid = 1'b0;
    rstn = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_cpu_rstn", {31'd0, cpu_rstn}, 32'd0);
    check("midrst_err", {31'd0, err}, 32'd0);
    wr_q.delete();
    send(8'h01, 0);
    settle();
    check("midrst_ignore_busy", {31'd0, busy}, 32'd0);
    check("midrst_ignore_nwr", 32'(wr_q.size()), 32'd0);

    // Randomized frames with noise between them.
    for (int k = 0; k < 12; k++) begin
      int cnt;
      bit bc;
      for (int n = 0; n < int'($urandom_range(0, 3)); n++) begin
        nb = 8'($urandom);
        if (nb == 8'hA5) nb = 8'h5A;
        send(nb, 0);
      end
      cnt = (k == 5) ? int'($urandom_range(513, 1023)) : int'($urandom_range(0, 20));
      bc  = ($urandom_range(0, 3) == 0);
      run_frame(cnt, bc, 1'b0);
    end

    // Full-depth frame of zeros.
    run_frame(512, 1'b0, 1'b1);
    check("full_last_addr", 32'(mif.mem_addr), 32'd511);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
